comp_eq: RTL and testbench
==========================

# comp_eq

Equality/magnitude comparator for the LBIST pattern path. Compares an N-bit operand A against a reference B and flags equality combinationally. In the random pattern generator, A is the LFSR state and B is the seed, so `res` marks the end of a pattern cycle. Optional clocked statistics count and record matches for BIST bookkeeping.

## Interface
- BITS, default 4: operand width, ≥2.
- CNT_W, default 16: width of the match counter, ≥1.

Ports:
- clk  input  1  clock; used only by the statistics logic.
- rst  input  1  reset, synchronous, active-high.
- A  input  BITS  operand under test (LFSR state).
- B  input  BITS  reference operand (seed).
- clr  input  1  synchronous clear of the statistics; active-high.
- res  output  1  1 when A == B; combinational.
- lt  output  1  1 when A < B, unsigned; combinational.
- gt  output  1  1 when A > B, unsigned; combinational.
- res_rise  output  1  1 when res is 1 now and was 0 at the previous clk edge.
- match_cnt  output  CNT_W  number of rising clk edges at which res was 1; saturating.
- match_seen  output  1  sticky flag, set by the first edge with res = 1.

## Operation
- Comparison outputs are pure combinational functions of A and B. They do not depend on clk, rst or clr.
- `res = (A == B)`, compared bitwise over all BITS bits.
- `lt` and `gt` use unsigned compare.
- Exactly one of res, lt, gt is 1 at any time.
- res_q is an internal register that holds res from the previous edge.
- `res_rise = res & ~res_q`. It is combinational from res and registered from res_q.
- At each rising clk edge, priority is rst, then clr, then normal update:
  - rst: match_cnt = 0, match_seen = 0, res_q = 0.
  - clr (with rst = 0): the same clearing as rst.
  - Normal update:
    - res_q ← res.
    - If res = 1: match_cnt increments by 1, holding at 2^CNT_W − 1 when it reaches that value, and match_seen ← 1.
- A match present at the same edge as rst or clr is discarded. It is not counted.
- X or Z on A or B is not defined for this block; the bench drives known values only.

## Timing
- res, lt and gt have zero-cycle latency and settle combinationally in the same cycle as A and B.
- res_rise is valid in the cycle res first goes high. It drops when res drops or at the next edge after res_q is set.
- match_cnt and match_seen update one edge after res is sampled high.
- Reset values after an rst edge: match_cnt = 0, match_seen = 0, res_q = 0.
  - res_rise then equals res.
  - res, lt and gt follow their inputs immediately.
- Before the first rst edge the registers are undefined. No reset-time requirement applies to res, lt or gt.
- Reset mid-count: the count is lost and counting restarts from 0 at the first edge after rst deasserts with res = 1.
- Saturation: at the maximum value the counter stays there; it does not wrap to 0.

## Configuration
- COMP_STATS_EN defined: the res_q, match_cnt and match_seen registers are built as described above.
- COMP_STATS_EN undefined:
  - No registers are built.
  - match_cnt is tied to 0 and match_seen is tied to 0.
  - res_rise is tied to 0.
  - clk, rst and clr are ignored.
  - res, lt and gt are unchanged.
- This allows a purely combinational instance, with clk, rst and clr tied off, inside the pattern generator.

## Test plan
- BITS = 4, B = 4'b1001, A swept 0..15 → res = 1 only at A = 9; lt = 1 for A < 9; gt = 1 for A > 9.
- COMP_STATS_EN defined, CNT_W = 4:
  - Sequence: assert rst; then hold A = B for 3 edges, A ≠ B for 2 edges, A = B for 1 edge.
  - Required: match_cnt = 4 and match_seen = 1.
  - res_rise high in the first cycle of each equal run only.
- CNT_W = 2, A = B held for 6 edges → match_cnt sequence 1, 2, 3, 3, 3, 3 (saturates, no wrap).
- Same-edge conflict:
  - Set match_cnt = 2, then assert clr at an edge where A = B → match_cnt = 0 and match_seen = 0.
  - Next edge with A = B and clr = 0 → match_cnt = 1.
- rst asserted mid-run with A = B → counters = 0 after that edge, res still 1; res_rise = 1 in the cycle after rst deasserts.
- COMP_STATS_EN undefined, BITS = 8, A = B = 8'hA5 with clk toggling → res = 1, match_cnt = 0, match_seen = 0, res_rise = 0.

Source files
------------

// File: rtl/comp_eq.sv
// comp_eq: equality/magnitude comparator with optional match statistics.
// Statistics registers are built only when COMP_STATS_EN is defined.
module comp_eq #(
  parameter int BITS  = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BITS-1:0]  A,
  input  logic [BITS-1:0]  B,
  input  logic             clr,
  output logic             res,
  output logic             lt,
  output logic             gt,
  output logic             res_rise,
  output logic [CNT_W-1:0] match_cnt,
  output logic             match_seen
);

  always_comb begin
    res = (A == B);
    lt  = (A < B);
    gt  = (A > B);
  end

`ifdef COMP_STATS_EN

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             res_q;
  logic [CNT_W-1:0] cnt_q;
  logic             seen_q;

  // A match on the same edge as rst/clr is dropped, not counted.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      res_q  <= 1'b0;
      cnt_q  <= '0;
      seen_q <= 1'b0;
    end else begin
      res_q <= res;
      if (res) begin
        seen_q <= 1'b1;
        if (cnt_q != CNT_MAX)
          cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    res_rise   = res & ~res_q;
    match_cnt  = cnt_q;
    match_seen = seen_q;
  end

`else

  logic unused_stats;

  always_comb begin
    unused_stats = ^{clk, rst, clr};
    res_rise     = 1'b0;
    match_cnt    = '0;
    match_seen   = 1'b0;
  end

`endif

endmodule

// File: tb/tb_comp_eq.sv
// tb_comp_eq: randomized and directed check of comp_eq against a
// behavioural model; covers both the stats and the combinational build.
module tb_comp_eq;

`ifdef COMP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] a4  = '0;
  logic [3:0] b4  = '0;
  logic [7:0] a8  = '0;
  logic [7:0] b8  = '0;

  logic        res4, lt4, gt4, rise4, seen4;
  logic [3:0]  cnt4;
  logic        res2, lt2, gt2, rise2, seen2;
  logic [1:0]  cnt2;
  logic        res8, lt8, gt8, rise8, seen8;
  logic [15:0] cnt8;

  comp_eq #(.BITS(4), .CNT_W(4)) u_w4 (
    .clk(clk), .rst(rst), .A(a4), .B(b4), .clr(clr),
    .res(res4), .lt(lt4), .gt(gt4), .res_rise(rise4),
    .match_cnt(cnt4), .match_seen(seen4)
  );

  comp_eq #(.BITS(4), .CNT_W(2)) u_w2 (
    .clk(clk), .rst(rst), .A(a4), .B(b4), .clr(clr),
    .res(res2), .lt(lt2), .gt(gt2), .res_rise(rise2),
    .match_cnt(cnt2), .match_seen(seen2)
  );

  comp_eq #(.BITS(8)) u_b8 (
    .clk(clk), .rst(rst), .A(a8), .B(b8), .clr(clr),
    .res(res8), .lt(lt8), .gt(gt8), .res_rise(rise8),
    .match_cnt(cnt8), .match_seen(seen8)
  );

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model: counts of matching edges since last rst/clr, plus previous res.
  int m_cnt4, m_cnt2, m_cnt8;
  bit m_seen, m_seen8, m_prev, m_prev8;

  always @(posedge clk) begin
    if (rst || clr) begin
      m_cnt4 = 0; m_cnt2 = 0; m_cnt8 = 0;
      m_seen = 0; m_seen8 = 0; m_prev = 0; m_prev8 = 0;
    end else begin
      m_prev  = (a4 == b4);
      m_prev8 = (a8 == b8);
      if (a4 == b4) begin
        m_seen = 1;
        m_cnt4 = (m_cnt4 + 1 > 15) ? 15 : m_cnt4 + 1;
        m_cnt2 = (m_cnt2 + 1 > 3)  ? 3  : m_cnt2 + 1;
      end
      if (a8 == b8) begin
        m_seen8 = 1;
        m_cnt8  = (m_cnt8 + 1 > 65535) ? 65535 : m_cnt8 + 1;
      end
    end
  end

  bit run = 0;

  always @(negedge clk) begin
    if (run) begin
      int ai, bi, ci, di;
      ai = a4; bi = b4; ci = a8; di = b8;
      chk("res4", res4, ai == bi);
      chk("lt4",  lt4,  ai <  bi);
      chk("gt4",  gt4,  ai >  bi);
      chk("res2", res2, ai == bi);
      chk("lt2",  lt2,  ai <  bi);
      chk("gt2",  gt2,  ai >  bi);
      chk("res8", res8, ci == di);
      chk("lt8",  lt8,  ci <  di);
      chk("gt8",  gt8,  ci >  di);
      chk("rise4", rise4, STATS ? ((ai == bi) && !m_prev) : 0);
      chk("rise2", rise2, STATS ? ((ai == bi) && !m_prev) : 0);
      chk("rise8", rise8, STATS ? ((ci == di) && !m_prev8) : 0);
      chk("cnt4",  cnt4,  STATS ? m_cnt4 : 0);
      chk("cnt2",  cnt2,  STATS ? m_cnt2 : 0);
      chk("cnt8",  cnt8,  STATS ? m_cnt8 : 0);
      chk("seen4", seen4, STATS ? m_seen : 0);
      chk("seen2", seen2, STATS ? m_seen : 0);
      chk("seen8", seen8, STATS ? m_seen8 : 0);
    end
  end

  // Drive just after a falling edge, then advance through one rising edge.
  task automatic cyc(input logic [3:0] a, input logic [3:0] b,
                     input logic r, input logic c);
    #1;
    a4 = a; b4 = b; rst = r; clr = c;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    cyc(4'd0, 4'd9, 1'b1, 1'b0);
    run = 1;
    chk("rst_cnt",  cnt4,  0);
    chk("rst_seen", seen4, 0);

    for (int i = 0; i < 16; i++) begin
      #1;
      a4 = 4'(i); b4 = 4'b1001; rst = 0; clr = 0;
      #1;
      chk("sweep_res", res4, i == 9);
      chk("sweep_lt",  lt4,  i < 9);
      chk("sweep_gt",  gt4,  i > 9);
      @(posedge clk);
      @(negedge clk);
    end

    cyc(4'd3, 4'd3, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(4'd5, 4'd5, 1'b0, 1'b0);
      chk("run1_rise_after", rise4, 0);
    end
    cyc(4'd6, 4'd5, 1'b0, 1'b0);
    cyc(4'd2, 4'd5, 1'b0, 1'b0);
    #1;
    a4 = 4'd5;
    #1;
    chk("run2_rise", rise4, STATS ? 1 : 0);
    @(posedge clk);
    @(negedge clk);
    chk("seq_cnt",  cnt4,  STATS ? 4 : 0);
    chk("seq_seen", seen4, STATS ? 1 : 0);

    cyc(4'd7, 4'd7, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cyc(4'd7, 4'd7, 1'b0, 1'b0);
      chk("sat_cnt2", cnt2, STATS ? ((i < 3) ? i + 1 : 3) : 0);
    end

    cyc(4'd1, 4'd1, 1'b1, 1'b0);
    cyc(4'd1, 4'd1, 1'b0, 1'b0);
    cyc(4'd1, 4'd1, 1'b0, 1'b0);
    chk("pre_clr_cnt", cnt4, STATS ? 2 : 0);
    cyc(4'd1, 4'd1, 1'b0, 1'b1);
    chk("clr_cnt",  cnt4,  0);
    chk("clr_seen", seen4, 0);
    cyc(4'd1, 4'd1, 1'b0, 1'b0);
    chk("post_clr_cnt", cnt4, STATS ? 1 : 0);

    cyc(4'd1, 4'd1, 1'b0, 1'b0);
    cyc(4'd1, 4'd1, 1'b1, 1'b0);
    chk("mid_rst_cnt",  cnt4,  0);
    chk("mid_rst_res",  res4,  1);
    chk("mid_rst_rise", rise4, STATS ? 1 : 0);

    #1;
    a8 = 8'hA5; b8 = 8'hA5;
    for (int i = 0; i < 4; i++) cyc(4'd0, 4'd1, 1'b0, 1'b0);
    chk("b8_res",  res8,  1);
    chk("b8_cnt",  cnt8,  STATS ? 4 : 0);
    chk("b8_seen", seen8, STATS ? 1 : 0);

    for (int i = 0; i < 400; i++) begin
      logic [3:0] ra, rb;
      logic [7:0] ra8;
      ra  = 4'($urandom_range(0, 15));
      rb  = ($urandom_range(0, 1) == 1) ? ra : 4'($urandom_range(0, 15));
      ra8 = 8'($urandom_range(0, 255));
      #1;
      a8 = ra8;
      b8 = ($urandom_range(0, 2) == 0) ? ra8 : 8'($urandom_range(0, 255));
      cyc(ra, rb, $urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
